// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
//   seq_state_t : FSM state encoding (also exported on the seq_state debug port)
//   cnt_width   : width of the shared hold/gap counter
package reset_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } seq_state_t;

    // Counter must hold values up to max(hold_cycles, stage_gap).
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned stage_gap);
        int unsigned m;
        m = (hold_cycles > stage_gap) ? hold_cycles : stage_gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Asynchronous-clear, synchronous-propagate flop chain.
//   clock : sampling clock
//   rst_n : async active-low clear of the whole chain (output goes 0 at once)
//   d     : data shifted in (tie to 1 for a classic reset synchroniser)
//   q     : last stage of the chain
module rst_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset manager: merges async reset sources and a software request, then
// releases NUM_OUT reset domains in order with programmable gaps, and keeps
// a sticky record of what caused the last reset.
//   clock     : system clock
//   resetn    : async active-low power-on reset, clears everything incl. cause
//   src_n     : async active-low reset sources
//   sw_req    : sync software reset request (honoured only in RUN)
//   cause_clr : sync clear of the cause register
//   rst_n_out : staged resets, async assert / sync deassert, index 0 first
//   ready     : all domains released
//   cause     : sticky cause, bit i = src_n[i] low, bit NUM_SRC = software
//   seq_state : current FSM state (debug)
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned NUM_OUT     = 3,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_SRC-1:0] src_n,
    input  logic               sw_req,
    input  logic               cause_clr,
    output logic [NUM_OUT-1:0] rst_n_out,
    output logic               ready,
    output logic [NUM_SRC:0]   cause,
    output logic [1:0]         seq_state
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int unsigned STG_W = $clog2(NUM_OUT + 1);

    if (SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGE_GAP < 1 ||
        NUM_OUT < 1 || NUM_SRC < 1) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    // Combined async reset: any source or the power-on reset clears the sequence.
    logic arst_n;
    assign arst_n = resetn & (&src_n);

    logic arst_sync;
    logic arst_ok;

    rst_sync #(.STAGES(SYNC_STAGES)) u_arst_sync (
        .clock (clock),
        .rst_n (arst_n),
        .d     (1'b1),
        .q     (arst_sync)
    );

    seq_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [STG_W-1:0]   stage, stage_next;
    logic [NUM_OUT-1:0] out_next;
    logic               ready_next;

    // State register; outputs are registered alongside so they never glitch.
    // arst_ok retimes the synchroniser output into the FSM's own flop domain.
    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            stage     <= '0;
            arst_ok   <= 1'b0;
            rst_n_out <= '0;
            ready     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            stage     <= stage_next;
            arst_ok   <= arst_sync;
            rst_n_out <= out_next;
            ready     <= ready_next;
        end
    end

    // Next-state: stage counts how many domains are released.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stage_next = stage;
        case (state)
            ST_ASSERT: begin
                cnt_next   = '0;
                stage_next = '0;
                if (arst_ok) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    cnt_next   = '0;
                    stage_next = STG_W'(1);
                    state_next = (NUM_OUT == 1) ? ST_RUN : ST_RELEASE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                    cnt_next   = '0;
                    stage_next = stage + STG_W'(1);
                    if (stage + STG_W'(1) == STG_W'(NUM_OUT)) begin
                        state_next = ST_RUN;
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (sw_req) begin
                    state_next = ST_ASSERT;
                    cnt_next   = '0;
                    stage_next = '0;
                end
            end
            default: begin
                state_next = ST_ASSERT;
            end
        endcase
    end

    // Output decode from next-state values, captured by the state register.
    always_comb begin
        out_next   = '0;
        ready_next = (state_next == ST_RUN);
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
            out_next[k] = (STG_W'(k) < stage_next);
        end
    end

    assign seq_state = state;

    // Cause capture: per-source sync flags a low source, kept alive by resetn only.
    logic [NUM_SRC-1:0] src_low;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_sync
        rst_sync #(.STAGES(2)) u_src_sync (
            .clock (clock),
            .rst_n (resetn),
            .d     (~src_n[i]),
            .q     (src_low[i])
        );
    end

    logic             sw_accept;
    logic [NUM_SRC:0] cause_set;

    assign sw_accept = (state == ST_RUN) && sw_req;
    assign cause_set = {sw_accept, src_low};

    // Set beats clear on the same edge, bit by bit.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cause <= '0;
        end else if (cause_clr) begin
            cause <= cause_set;
        end else begin
            cause <= cause | cause_set;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a minimal one
// (NUM_OUT=1, HOLD_CYCLES=1, STAGE_GAP=1, SYNC_STAGES=3) share all inputs.
// The reference model tracks, per instance, the number of edges since the
// sequence's virtual edge 0 and derives outputs from the release thresholds.
module tb_reset_sequencer;

    logic       clock;
    logic       resetn;
    logic [1:0] src_n;
    logic       sw_req;
    logic       cause_clr;

    logic [2:0] out_a;
    logic       rdy_a;
    logic [2:0] cause_a;
    logic [1:0] st_a;

    logic [0:0] out_b;
    logic       rdy_b;
    logic [2:0] cause_b;
    logic [1:0] st_b;

    reset_sequencer dut_a (
        .clock     (clock),
        .resetn    (resetn),
        .src_n     (src_n),
        .sw_req    (sw_req),
        .cause_clr (cause_clr),
        .rst_n_out (out_a),
        .ready     (rdy_a),
        .cause     (cause_a),
        .seq_state (st_a)
    );

    reset_sequencer #(
        .NUM_SRC     (2),
        .NUM_OUT     (1),
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1),
        .STAGE_GAP   (1)
    ) dut_b (
        .clock     (clock),
        .resetn    (resetn),
        .src_n     (src_n),
        .sw_req    (sw_req),
        .cause_clr (cause_clr),
        .rst_n_out (out_b),
        .ready     (rdy_b),
        .cause     (cause_b),
        .seq_state (st_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         total = 0;
    int         bad   = 0;
    int         age [2];
    logic [2:0] mcause [2];
    int         quiet;
    int         rise_a [3];
    int         rise_rdy_a;
    int         rise_b;

    // Configuration c=0: default instance, c=1: minimal instance.
    function automatic int sync_of(input int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic int nout_of(input int c);
        return (c == 0) ? 3 : 1;
    endfunction

    // Edge (relative to edge 0) at which out[k] is released.
    function automatic int thr(input int c, input int k);
        if (c == 0) return 2 + 1 + 16 + k * 4;
        return 3 + 1 + 1 + k * 1;
    endfunction

    function automatic int thr_last(input int c);
        return thr(c, nout_of(c) - 1);
    endfunction

    function automatic logic [1:0] exp_state(input int c);
        if (age[c] < sync_of(c) + 1) return 2'd0;
        if (age[c] >= thr_last(c))   return 2'd3;
        if (age[c] >= thr(c, 0))     return 2'd2;
        return 2'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Async effects of the bench's own input changes.
    task automatic async_update();
        if (!(resetn && (&src_n))) begin
            age[0] = -1;
            age[1] = -1;
        end
        if (!resetn) begin
            mcause[0] = '0;
            mcause[1] = '0;
        end
    endtask

    // Model update for one clock edge, using the inputs held across it.
    task automatic model_edge();
        logic       a;
        logic       acc;
        logic [2:0] set;
        a = resetn && (&src_n);
        for (int c = 0; c < 2; c++) begin
            acc = a && sw_req && (age[c] >= thr_last(c));
            set = {acc, ~src_n};
            if (!resetn)        mcause[c] = '0;
            else if (cause_clr) mcause[c] = set;
            else                mcause[c] = mcause[c] | set;
            if (!a)               age[c] = -1;
            else if (acc)         age[c] = sync_of(c);
            else if (age[c] < 1000000) age[c]++;
        end
        if (quiet < 1000) quiet++;
    endtask

    task automatic check_all();
        logic [2:0] eo;
        for (int c = 0; c < 2; c++) begin
            eo = '0;
            for (int k = 0; k < nout_of(c); k++) eo[k] = (age[c] >= thr(c, k));
            if (c == 0) begin
                chk("out_a", 32'(out_a), 32'(eo));
                chk("ready_a", 32'(rdy_a), 32'(age[0] >= thr_last(0)));
                chk("state_a", 32'(st_a), 32'(exp_state(0)));
                if (quiet >= 3) chk("cause_a", 32'(cause_a), 32'(mcause[0]));
            end else begin
                chk("out_b", 32'(out_b), 32'(eo[0]));
                chk("ready_b", 32'(rdy_b), 32'(age[1] >= thr_last(1)));
                chk("state_b", 32'(st_b), 32'(exp_state(1)));
                if (quiet >= 3) chk("cause_b", 32'(cause_b), 32'(mcause[1]));
            end
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #2;
        check_all();
    endtask

    task automatic set_src(input logic [1:0] v);
        if (v !== src_n) quiet = 0;
        src_n = v;
        async_update();
        #2;
        check_all();
    endtask

    task automatic set_resetn(input logic v);
        resetn = v;
        quiet  = 0;
        async_update();
        #2;
        check_all();
    endtask

    task automatic clear_rises();
        for (int k = 0; k < 3; k++) rise_a[k] = -1;
        rise_rdy_a = -1;
        rise_b     = -1;
    endtask

    task automatic record(input int e);
        for (int k = 0; k < 3; k++) if (out_a[k] === 1'b1 && rise_a[k] < 0) rise_a[k] = e;
        if (rdy_a === 1'b1 && rise_rdy_a < 0) rise_rdy_a = e;
        if (out_b[0] === 1'b1 && rise_b < 0) rise_b = e;
    endtask

    // Runs n edges; the first edge is numbered 0.
    task automatic measure(input int n);
        clear_rises();
        for (int e = 0; e < n; e++) begin
            step();
            record(e);
        end
    endtask

    initial begin
        logic [1:0] v;
        int         len;
        resetn    = 1'b0;
        src_n     = 2'b11;
        sw_req    = 1'b0;
        cause_clr = 1'b0;
        quiet     = 0;
        age[0]    = -1;
        age[1]    = -1;
        mcause[0] = '0;
        mcause[1] = '0;

        // Power-on
        repeat (3) step();
        chk("por_out_a", 32'(out_a), 32'd0);
        chk("por_state_a", 32'(st_a), 32'd0);
        chk("por_cause_a", 32'(cause_a), 32'd0);
        set_resetn(1'b1);
        measure(35);
        chk("por_rise_a0", 32'(rise_a[0]), 32'd19);
        chk("por_rise_a1", 32'(rise_a[1]), 32'd23);
        chk("por_rise_a2", 32'(rise_a[2]), 32'd27);
        chk("por_ready_a", 32'(rise_rdy_a), 32'd27);
        chk("por_rise_b", 32'(rise_b), 32'd5);
        chk("por_cause_a0", 32'(cause_a), 32'd0);
        chk("por_run_a", 32'(st_a), 32'd3);

        // Source 1 low for 5 cycles while running
        set_src(2'b01);
        chk("src1_drop_a", 32'({rdy_a, out_a}), 32'd0);
        chk("src1_drop_b", 32'({rdy_b, out_b}), 32'd0);
        repeat (5) step();
        chk("src1_cause_a", 32'(cause_a), 32'b010);
        chk("src1_cause_b", 32'(cause_b), 32'b010);
        set_src(2'b11);
        measure(21);
        chk("src1_rise_a0", 32'(rise_a[0]), 32'd19);
        chk("src1_rise_b", 32'(rise_b), 32'd5);
        chk("src1_mid_release", 32'(out_a), 32'b001);

        // Source 0 pulse during RELEASE
        set_src(2'b10);
        chk("src0_drop_a", 32'({rdy_a, out_a}), 32'd0);
        chk("src0_state_a", 32'(st_a), 32'd0);
        repeat (3) step();
        set_src(2'b11);
        measure(35);
        chk("src0_rise_a0", 32'(rise_a[0]), 32'd19);
        chk("src0_rise_a2", 32'(rise_a[2]), 32'd27);
        chk("src0_ready_a", 32'(rise_rdy_a), 32'd27);
        chk("src0_rise_b", 32'(rise_b), 32'd5);
        chk("src0_cause_a", 32'(cause_a), 32'b011);

        // Software reset together with cause clear, then sw_req during HOLD
        sw_req    = 1'b1;
        cause_clr = 1'b1;
        step();
        sw_req    = 1'b0;
        cause_clr = 1'b0;
        chk("sw_out_a", 32'({rdy_a, out_a}), 32'd0);
        chk("sw_state_a", 32'(st_a), 32'd0);
        chk("sw_cause_a", 32'(cause_a), 32'b100);
        chk("sw_cause_b", 32'(cause_b), 32'b100);
        clear_rises();
        for (int e = 1; e <= 25; e++) begin
            if (e == 6) sw_req = 1'b1;
            step();
            sw_req = 1'b0;
            record(e);
        end
        chk("sw_rise_a0", 32'(rise_a[0]), 32'd17);
        chk("sw_rise_b", 32'(rise_b), 32'd2);
        cause_clr = 1'b1;
        step();
        cause_clr = 1'b0;
        chk("clr_cause_a", 32'(cause_a), 32'd0);
        chk("clr_cause_b", 32'(cause_b), 32'd0);

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    v = 2'b11;
                    v[$urandom_range(0, 1)] = 1'b0;
                    len = int'($urandom_range(3, 6));
                    set_src(v);
                    repeat (len) step();
                    set_src(2'b11);
                end
                1: begin
                    sw_req = 1'b1;
                    step();
                    sw_req = 1'b0;
                end
                2: begin
                    if (quiet >= 3) begin
                        cause_clr = 1'b1;
                        step();
                        cause_clr = 1'b0;
                    end
                end
                default: begin
                    repeat ($urandom_range(1, 30)) step();
                end
            endcase
        end

        // Power-on reset clears the cause
        repeat (30) step();
        set_resetn(1'b0);
        step();
        chk("final_cause_a", 32'(cause_a), 32'd0);
        chk("final_cause_b", 32'(cause_b), 32'd0);
        set_resetn(1'b1);
        measure(30);
        chk("final_ready_a", 32'(rise_rdy_a), 32'd27);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
